// File: rtl/udp_port_dispatch.sv
// UDP RX payload demux: routes each frame to the channel picked by its destination port, drops and counts the rest.
// Latency: payload path is combinational; the header is routed one cycle after its handshake.
// Backpressure: s_tready follows the selected channel's m_tready; drops are always accepted; no payload is accepted in IDLE.
//
// Ports:
//   clock, reset                   rising-edge clock, synchronous active-high reset
//   s_hdr_*                        UDP header (destination port) with valid/ready
//   s_t*                           incoming payload stream (tuser = frame error on the tlast beat)
//   m_t*                           outgoing payload; data/last/user are shared, m_tvalid/m_tready are per channel
//   cap_data, cap_valid            first CAP_BYTES bytes of the last good frame, per channel
//   drop_count                     saturating count of headers that matched no channel
//   busy                           high while a frame is being forwarded or dropped
module udp_port_dispatch #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CH     = 4,
   parameter int PORT_BASE  = 1234,
   parameter int CAP_BYTES  = 4,
   parameter int CNT_W      = 16
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              s_hdr_valid,
   output logic                              s_hdr_ready,
   input  logic [15:0]                       s_hdr_dest_port,
   input  logic [DATA_WIDTH-1:0]             s_tdata,
   input  logic                              s_tvalid,
   output logic                              s_tready,
   input  logic                              s_tlast,
   input  logic                              s_tuser,
   output logic [DATA_WIDTH-1:0]             m_tdata,
   output logic [NUM_CH-1:0]                 m_tvalid,
   input  logic [NUM_CH-1:0]                 m_tready,
   output logic                              m_tlast,
   output logic                              m_tuser,
   output logic [NUM_CH*CAP_BYTES*8-1:0]     cap_data,
   output logic [NUM_CH-1:0]                 cap_valid,
   output logic [CNT_W-1:0]                  drop_count,
   output logic                              busy
);

   localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int IDX_W = $clog2(CAP_BYTES + 1);
   localparam int CAP_W = CAP_BYTES * 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FWD  = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   logic [1:0]              state;
   logic [SEL_W-1:0]        sel;
   logic [IDX_W-1:0]        idx;
   logic [CAP_W-1:0]        shadow;
   logic [CAP_W-1:0]        shadow_nxt;
   logic [NUM_CH*CAP_W-1:0] cap_data_q;
   logic [NUM_CH-1:0]       cap_valid_q;
   logic [CNT_W-1:0]        drop_count_q;

   logic [15:0]             port_off;
   logic                    port_hit;
   logic                    hdr_fire;
   logic                    beat_fire;
   logic [NUM_CH-1:0]       sel_onehot;

   // Both bounds are checked: the lower one on a 17-bit compare so that a
   // wrapped port_off can never alias into the channel range.
   assign port_off = s_hdr_dest_port - 16'(PORT_BASE);
   assign port_hit = ({1'b0, s_hdr_dest_port} >= 17'(PORT_BASE)) && (port_off < 16'(NUM_CH));

   assign hdr_fire  = s_hdr_valid && s_hdr_ready;
   assign beat_fire = s_tvalid && s_tready;

   always_comb begin
      sel_onehot = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (sel == SEL_W'(c)) sel_onehot[c] = 1'b1;
      end
   end

   // Shadow with the current beat folded in, so the tlast byte is part of the commit.
   always_comb begin
      shadow_nxt = shadow;
      for (int b = 0; b < CAP_BYTES; b++) begin
         if (idx == IDX_W'(b)) shadow_nxt[b*8 +: 8] = s_tdata[7:0];
      end
   end

   always_comb begin
      s_hdr_ready = 1'b0;
      s_tready    = 1'b0;
      m_tvalid    = '0;
      case (state)
         ST_IDLE: s_hdr_ready = 1'b1;
         ST_FWD: begin
            s_tready = |(m_tready & sel_onehot);
            m_tvalid = s_tvalid ? sel_onehot : '0;
         end
         ST_DROP: s_tready = 1'b1;
         default: s_hdr_ready = 1'b0;
      endcase
   end

   assign m_tdata    = s_tdata;
   assign m_tlast    = s_tlast;
   assign m_tuser    = s_tuser;
   assign cap_data   = cap_data_q;
   assign cap_valid  = cap_valid_q;
   assign drop_count = drop_count_q;
   assign busy       = (state != ST_IDLE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         sel          <= '0;
         idx          <= '0;
         shadow       <= '0;
         cap_data_q   <= '0;
         cap_valid_q  <= '0;
         drop_count_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (hdr_fire) begin
                  shadow <= '0;
                  idx    <= '0;
                  if (port_hit) begin
                     sel   <= port_off[SEL_W-1:0];
                     state <= ST_FWD;
                  end else begin
                     state <= ST_DROP;
                     if (drop_count_q != '1) drop_count_q <= drop_count_q + CNT_W'(1);
                  end
               end
            end
            ST_FWD: begin
               if (beat_fire) begin
                  shadow <= shadow_nxt;
                  if (idx < IDX_W'(CAP_BYTES)) idx <= idx + IDX_W'(1);
                  if (s_tlast) begin
                     state <= ST_IDLE;
                     // Errored frames leave the previous capture in place.
                     if (!s_tuser) begin
                        for (int c = 0; c < NUM_CH; c++) begin
                           if (sel_onehot[c]) begin
                              cap_data_q[c*CAP_W +: CAP_W] <= shadow_nxt;
                              cap_valid_q[c]               <= 1'b1;
                           end
                        end
                     end
                  end
               end
            end
            ST_DROP: begin
               if (beat_fire && s_tlast) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udp_port_dispatch.sv
module tb_udp_port_dispatch;

   logic         clock;
   logic         reset;
   logic         s_hdr_valid;
   logic         s_hdr_ready, s_hdr_ready_b;
   logic [15:0]  s_hdr_dest_port;
   logic [7:0]   s_tdata;
   logic         s_tvalid;
   logic         s_tready, s_tready_b;
   logic         s_tlast;
   logic         s_tuser;
   logic [7:0]   m_tdata, m_tdata_b;
   logic [3:0]   m_tvalid, m_tvalid_b;
   logic [3:0]   m_tready;
   logic         m_tlast, m_tlast_b;
   logic         m_tuser, m_tuser_b;
   logic [127:0] cap_data, cap_data_b;
   logic [3:0]   cap_valid, cap_valid_b;
   logic [15:0]  drop_count;
   logic [1:0]   drop_count_b;
   logic         busy, busy_b;

   udp_port_dispatch dut (
      .clock(clock), .reset(reset),
      .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready), .s_hdr_dest_port(s_hdr_dest_port),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tuser(s_tuser),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser),
      .cap_data(cap_data), .cap_valid(cap_valid), .drop_count(drop_count), .busy(busy)
   );

   // Second instance sees identical stimulus; only its narrow drop counter is examined.
   udp_port_dispatch #(.CNT_W(2)) dut_b (
      .clock(clock), .reset(reset),
      .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready_b), .s_hdr_dest_port(s_hdr_dest_port),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready_b), .s_tlast(s_tlast), .s_tuser(s_tuser),
      .m_tdata(m_tdata_b), .m_tvalid(m_tvalid_b), .m_tready(m_tready), .m_tlast(m_tlast_b), .m_tuser(m_tuser_b),
      .cap_data(cap_data_b), .cap_valid(cap_valid_b), .drop_count(drop_count_b), .busy(busy_b)
   );

   typedef struct packed {
      logic [3:0] ch;
      logic [7:0] dat;
      logic       last;
      logic       user;
   } beat_t;

   beat_t exp_q[$];
   int    n_checks = 0;
   int    n_errors = 0;
   int    last_hdr_wait;
   logic  tog = 1'b0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: every delivered beat must be the next expected one.
   always @(negedge clock) begin
      if (!reset) begin
         for (int c = 0; c < 4; c++) begin
            if (m_tvalid[c] && m_tready[c]) begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_errors++;
                  $display("FAIL beat_unexpected: got ch%0d data %0h, nothing expected", c, m_tdata);
               end else begin
                  beat_t e, a;
                  e = exp_q.pop_front();
                  a = '{ch: 4'(c), dat: m_tdata, last: m_tlast, user: m_tuser};
                  if (a !== e || $countones(m_tvalid) != 1) begin
                     n_errors++;
                     $display("FAIL beat: got ch%0d %0h last %0b user %0b tvalid %b, expected ch%0d %0h last %0b user %0b",
                              a.ch, a.dat, a.last, a.user, m_tvalid, e.ch, e.dat, e.last, e.user);
                  end
               end
            end
         end
      end
   end

   task automatic send_hdr(input logic [15:0] p);
      int w;
      w = 0;
      s_hdr_valid = 1'b1;
      s_hdr_dest_port = p;
      forever begin
         @(negedge clock);
         if (s_hdr_ready) break;
         w++;
         if (w > 20) begin
            n_checks++; n_errors++;
            $display("FAIL hdr_timeout: got no s_hdr_ready, required 1");
            break;
         end
      end
      last_hdr_wait = w;
      @(posedge clock); #1;
      s_hdr_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [7:0] d, input logic l, input logic u,
                            output int waits, output logic [3:0] mtv);
      logic acc;
      acc = 1'b0;
      waits = 0;
      mtv = '0;
      s_tvalid = 1'b1; s_tdata = d; s_tlast = l; s_tuser = u;
      forever begin
         @(negedge clock);
         acc = s_tready;
         mtv = m_tvalid;
         if (!acc) waits++;
         @(posedge clock); #1;
         if (tog) m_tready = m_tready ^ 4'b1000;
         if (acc || waits > 20) break;
      end
      if (!acc) begin
         n_checks++; n_errors++;
         $display("FAIL beat_timeout: got s_tready 0, required 1");
      end
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
   endtask

   // ch < 0 means the frame is expected to be dropped.
   task automatic send_frame(input logic [15:0] p, input int n, input logic [7:0] d[8],
                             input logic bad, input int ch);
      int w;
      logic [3:0] mtv;
      send_hdr(p);
      for (int i = 0; i < n; i++) begin
         if (ch >= 0) exp_q.push_back('{ch: 4'(ch), dat: d[i], last: (i == n-1), user: bad && (i == n-1)});
         send_beat(d[i], i == n-1, bad && (i == n-1), w, mtv);
         if (ch < 0) begin
            chk("drop_tready_wait", 64'(w), 64'd0);
            chk("drop_m_tvalid", 64'(mtv), 64'd0);
         end
      end
   endtask

   initial begin
      int w;
      logic [3:0] mtv;
      #200000;
      $display("FAIL watchdog: got no finish, required finish before 200us");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      logic [3:0] mtv;
      reset = 1'b1;
      s_hdr_valid = 1'b0; s_hdr_dest_port = '0;
      s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
      m_tready = 4'hF;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_hdr_ready", 64'(s_hdr_ready), 64'd1);
      chk("rst_tready",    64'(s_tready),    64'd0);
      chk("rst_m_tvalid",  64'(m_tvalid),    64'd0);
      chk("rst_busy",      64'(busy),        64'd0);
      chk("rst_cap_valid", 64'(cap_valid),   64'd0);
      chk("rst_drop",      64'(drop_count),  64'd0);
      reset = 1'b0;
      @(posedge clock); #1;

      // Port 1234, full 4-byte capture.
      send_hdr(16'd1234);
      chk("busy_fwd", 64'(busy), 64'd1);
      foreach (exp_q[i]) ;
      begin
         logic [7:0] d[8];
         d = '{8'hA5, 8'h3C, 8'h0F, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00};
         for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{ch: 4'd0, dat: d[i], last: (i == 3), user: 1'b0});
            send_beat(d[i], i == 3, 1'b0, w, mtv);
         end
      end
      chk("cap0", 64'(cap_data[0 +: 32]), 64'h810F3CA5);
      chk("cap_valid_a", 64'(cap_valid), 64'b0001);
      chk("busy_idle", 64'(busy), 64'd0);

      // Port 1237, short frame with m_tready[3] toggling each cycle.
      tog = 1'b1;
      send_frame(16'd1237, 2, '{8'h11, 8'h22, 0, 0, 0, 0, 0, 0}, 1'b0, 3);
      tog = 1'b0;
      m_tready = 4'hF;
      chk("cap3", 64'(cap_data[96 +: 32]), 64'h00002211);
      chk("cap_valid_b", 64'(cap_valid), 64'b1001);

      // Port 80 is dropped.
      send_hdr(16'd80);
      chk("drop_cnt_1", 64'(drop_count), 64'd1);
      chk("drop_cnt_1_narrow", 64'(drop_count_b), 64'd1);
      for (int i = 0; i < 5; i++) begin
         send_beat(8'(i + 1), i == 4, 1'b0, w, mtv);
         chk("drop_tready_wait", 64'(w), 64'd0);
         chk("drop_m_tvalid", 64'(mtv), 64'd0);
      end
      chk("cap_valid_after_drop", 64'(cap_valid), 64'b1001);

      // Good frame on 1235, then an errored one that must not overwrite it.
      send_frame(16'd1235, 4, '{8'h01, 8'h02, 8'h03, 8'h04, 0, 0, 0, 0}, 1'b0, 1);
      chk("cap1_good", 64'(cap_data[32 +: 32]), 64'h04030201);
      send_frame(16'd1235, 2, '{8'hAA, 8'hBB, 0, 0, 0, 0, 0, 0}, 1'b1, 1);
      chk("cap1_kept", 64'(cap_data[32 +: 32]), 64'h04030201);
      chk("cap_valid_c", 64'(cap_valid), 64'b1011);

      // Just outside the channel range on both sides, then far outside.
      send_frame(16'd1233, 1, '{8'h5A, 0, 0, 0, 0, 0, 0, 0}, 1'b0, -1);
      send_frame(16'd1238, 2, '{8'h5B, 8'h5C, 0, 0, 0, 0, 0, 0}, 1'b0, -1);
      chk("drop_cnt_3", 64'(drop_count), 64'd3);
      send_frame(16'd65535, 1, '{8'h01, 0, 0, 0, 0, 0, 0, 0}, 1'b0, -1);
      send_frame(16'd0, 1, '{8'h02, 0, 0, 0, 0, 0, 0, 0}, 1'b0, -1);
      chk("drop_cnt_5", 64'(drop_count), 64'd5);
      chk("drop_cnt_sat", 64'(drop_count_b), 64'd3);

      // Header issued in the cycle right after the previous tlast.
      send_frame(16'd1236, 5, '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h77, 0, 0, 0}, 1'b0, 2);
      chk("b2b_hdr_wait", 64'(last_hdr_wait), 64'd0);
      chk("cap2_long", 64'(cap_data[64 +: 32]), 64'hEFBEADDE);
      chk("cap_valid_d", 64'(cap_valid), 64'b1111);

      // Reset in the middle of a 1236 frame.
      send_hdr(16'd1236);
      exp_q.push_back('{ch: 4'd2, dat: 8'h55, last: 1'b0, user: 1'b0});
      send_beat(8'h55, 1'b0, 1'b0, w, mtv);
      exp_q.push_back('{ch: 4'd2, dat: 8'h66, last: 1'b0, user: 1'b0});
      send_beat(8'h66, 1'b0, 1'b0, w, mtv);
      reset = 1'b1;
      s_tvalid = 1'b1; s_tdata = 8'h99;
      @(posedge clock); #1;
      chk("mid_rst_hdr_ready", 64'(s_hdr_ready), 64'd1);
      chk("mid_rst_tready",    64'(s_tready),    64'd0);
      chk("mid_rst_m_tvalid",  64'(m_tvalid),    64'd0);
      chk("mid_rst_busy",      64'(busy),        64'd0);
      chk("mid_rst_cap_valid", 64'(cap_valid),   64'd0);
      chk("mid_rst_cap_data",  64'(cap_data[64 +: 32]), 64'd0);
      chk("mid_rst_drop",      64'(drop_count),  64'd0);
      s_tvalid = 1'b0;
      reset = 1'b0;
      @(posedge clock); #1;

      // One-byte frame after the reset.
      send_frame(16'd1236, 1, '{8'h9A, 0, 0, 0, 0, 0, 0, 0}, 1'b0, 2);
      chk("cap2_one_byte", 64'(cap_data[64 +: 32]), 64'h0000009A);
      chk("cap_valid_e", 64'(cap_valid), 64'b0100);

      repeat (3) @(posedge clock);
      #1;
      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
